// File: rtl/uart_rx_if.sv
// Receive-side UART bus: line and divider in, received byte and status strobes out.
// The DUT side is the slave modport; the driver/consumer side is the master modport.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [3:0]           clk_div;
  logic                 Rx_Serial;
  logic [DATA_BITS-1:0] Rx_Data;
  logic                 Rx_Valid;
  logic                 Rx_Active;
  logic                 Frame_Err;
  logic                 Parity_Err;

  modport master (
    output clk_div, Rx_Serial,
    input  Rx_Data, Rx_Valid, Rx_Active, Frame_Err, Parity_Err
  );

  modport slave (
    input  clk_div, Rx_Serial,
    output Rx_Data, Rx_Valid, Rx_Active, Frame_Err, Parity_Err
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: start/8N1 frame sampled at mid-bit with a clk_div bit period.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic   clk,
  input logic   rst,
  uart_rx_if.slave bus
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [3:0]           count_q, count_d;
  logic [3:0]           eff_q, eff_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 active_q, active_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
`ifdef UART_RX_PARITY_EN
  logic                 pflag_q, pflag_d;
`endif

  logic       rxs_s;
  logic [3:0] eff_in_s;
  logic       half_hit_s;
  logic       bit_hit_s;

  assign rxs_s      = sync_q[SYNC_STAGES-1];
  assign eff_in_s   = (bus.clk_div < 4'd2) ? 4'd2 : bus.clk_div;
  assign half_hit_s = (count_q == ((eff_q >> 1) - 4'd1));
  assign bit_hit_s  = (count_q == (eff_q - 4'd1));
  assign sync_d     = {sync_q[SYNC_STAGES-2:0], bus.Rx_Serial};

  // State register and all datapath/output flops; synchronizer resets to idle-high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      sync_q   <= {SYNC_STAGES{1'b1}};
      count_q  <= 4'd0;
      eff_q    <= 4'd2;
      idx_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
      ferr_q   <= 1'b0;
      perr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pflag_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      count_q  <= count_d;
      eff_q    <= eff_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      active_q <= active_d;
      ferr_q   <= ferr_d;
      perr_q   <= perr_d;
`ifdef UART_RX_PARITY_EN
      pflag_q  <= pflag_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!rxs_s) state_d = START;
        else        state_d = IDLE;
      end
      START: begin
        if (half_hit_s) state_d = rxs_s ? IDLE : DATA;
        else            state_d = START;
      end
      DATA: begin
        if (bit_hit_s && (idx_q == LAST_IDX)) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end else begin
          state_d = DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_hit_s) state_d = STOP;
        else           state_d = PARITY;
      end
`endif
      STOP: begin
        if (bit_hit_s) state_d = IDLE;
        else           state_d = STOP;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters, shift register and next values of the registered outputs.
  always_comb begin
    count_d  = count_q;
    eff_d    = eff_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    data_d   = data_q;
    active_d = active_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    perr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    pflag_d  = pflag_q;
`endif
    case (state_q)
      IDLE: begin
        count_d = 4'd0;
`ifdef UART_RX_PARITY_EN
        pflag_d = 1'b0;
`endif
        if (!rxs_s) eff_d = eff_in_s;
        else        eff_d = eff_q;
      end
      START: begin
        if (half_hit_s) begin
          count_d = 4'd0;
          idx_d   = '0;
          if (!rxs_s) active_d = 1'b1;
          else        active_d = 1'b0;
        end else begin
          count_d = count_q + 4'd1;
        end
      end
      DATA: begin
        if (bit_hit_s) begin
          shift_d[idx_q] = rxs_s;
          count_d        = 4'd0;
          if (idx_q != LAST_IDX) idx_d = idx_q + IDX_W'(1);
          else                   idx_d = idx_q;
        end else begin
          count_d = count_q + 4'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_hit_s) begin
          pflag_d = (^shift_q) ^ rxs_s;
          count_d = 4'd0;
        end else begin
          count_d = count_q + 4'd1;
        end
      end
`endif
      STOP: begin
        if (bit_hit_s) begin
          count_d  = 4'd0;
          active_d = 1'b0;
          if (rxs_s) begin
`ifdef UART_RX_PARITY_EN
            if (pflag_q) begin
              perr_d = 1'b1;
            end else begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
`else
            data_d  = shift_q;
            valid_d = 1'b1;
`endif
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          count_d = count_q + 4'd1;
        end
      end
      default: begin
        count_d  = 4'd0;
        active_d = 1'b0;
      end
    endcase
  end

  assign bus.Rx_Data    = data_q;
  assign bus.Rx_Valid   = valid_q;
  assign bus.Rx_Active  = active_q;
  assign bus.Frame_Err  = ferr_q;
  assign bus.Parity_Err = perr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx; frames are driven bit by bit from the bench.
// Build with UART_RX_PARITY_EN defined to exercise the parity variant as well.
module tb_uart_rx;

  logic clk;
  logic rst;

  uart_rx_if #(.DATA_BITS(8)) bus ();

  uart_rx #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int frame_start;
  int first_valid;
  int first_active;
  int n_valid;
  int n_ferr;
  int n_perr;
  int n_excl   = 0;
  logic [7:0] rx_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    first_valid  = -1;
    first_active = -1;
    n_valid      = 0;
    n_ferr       = 0;
    n_perr       = 0;
    rx_q.delete();
    frame_start  = cyc;
  endtask

  // One clock: advance, then observe the DUT 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.Rx_Valid === 1'b1) begin
      n_valid++;
      rx_q.push_back(bus.Rx_Data);
      if (first_valid < 0) first_valid = cyc - frame_start;
    end
    if (bus.Frame_Err === 1'b1)  n_ferr++;
    if (bus.Parity_Err === 1'b1) n_perr++;
    if (bus.Rx_Active === 1'b1 && first_active < 0) first_active = cyc - frame_start;
    if ((int'(bus.Rx_Valid) + int'(bus.Frame_Err) + int'(bus.Parity_Err)) > 1) n_excl++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input logic par_bit, input int bp);
    bus.Rx_Serial = 1'b0;
    ticks(bp);
    for (int i = 0; i < 8; i++) begin
      bus.Rx_Serial = d[i];
      ticks(bp);
    end
    if (PAR_BITS == 1) begin
      bus.Rx_Serial = par_bit;
      ticks(bp);
    end
    bus.Rx_Serial = stop_bit;
    ticks(bp);
    bus.Rx_Serial = 1'b1;
  endtask

  initial begin
    int lat_lo;
    int lat_hi;
    lat_lo = 96 + 10 * PAR_BITS;
    lat_hi = 99 + 10 * PAR_BITS;

    rst           = 1'b0;
    bus.Rx_Serial = 1'b1;
    bus.clk_div   = 4'd10;
    clear_counts();
    ticks(2);
    rst = 1'b1;
    ticks(5);
    chk("reset_data",   32'(bus.Rx_Data),    32'h00);
    chk("reset_valid",  32'(bus.Rx_Valid),   32'h0);
    chk("reset_active", 32'(bus.Rx_Active),  32'h0);
    chk("reset_ferr",   32'(bus.Frame_Err),  32'h0);
    chk("reset_perr",   32'(bus.Parity_Err), 32'h0);

    // Frame 0xA5 (even parity bit of 0xA5 is 0)
    clear_counts();
    send_frame(8'hA5, 1'b1, 1'b0, 10);
    ticks(20);
    chk("a5_nvalid", 32'(n_valid), 32'd1);
    chk("a5_data",   32'(bus.Rx_Data), 32'hA5);
    chk("a5_ferr",   32'(n_ferr), 32'd0);
    chk("a5_active_start", 32'(first_active >= 7 && first_active <= 9), 32'd1);
    chk("a5_latency", 32'(first_valid >= lat_lo && first_valid <= lat_hi), 32'd1);
    chk("a5_active_end", 32'(bus.Rx_Active), 32'h0);

    // Frame 0x5A with a bad stop bit: Frame_Err only, data held
    clear_counts();
    send_frame(8'h5A, 1'b0, 1'b0, 10);
    ticks(25);
    chk("ferr_count",  32'(n_ferr),  32'd1);
    chk("ferr_nvalid", 32'(n_valid), 32'd0);
    chk("ferr_data",   32'(bus.Rx_Data), 32'hA5);
    chk("ferr_perr",   32'(n_perr), 32'd0);

    // 3-clock low glitch on an idle line
    clear_counts();
    bus.Rx_Serial = 1'b0;
    ticks(3);
    bus.Rx_Serial = 1'b1;
    ticks(20);
    chk("glitch_active", 32'(first_active), 32'hFFFFFFFF);
    chk("glitch_valid",  32'(n_valid), 32'd0);
    chk("glitch_ferr",   32'(n_ferr),  32'd0);

    // Frame 0x3C; clk_div changes mid-frame must not matter (parity 0)
    clear_counts();
    bus.Rx_Serial = 1'b0;
    ticks(10);
    bus.clk_div = 4'd3;
    for (int i = 0; i < 8; i++) begin
      bus.Rx_Serial = (8'h3C >> i) & 8'h01;
      ticks(10);
    end
    if (PAR_BITS == 1) begin
      bus.Rx_Serial = 1'b0;
      ticks(10);
    end
    bus.Rx_Serial = 1'b1;
    ticks(30);
    bus.clk_div = 4'd10;
    chk("c3_nvalid", 32'(n_valid), 32'd1);
    chk("c3_data",   32'(bus.Rx_Data), 32'h3C);

    // clk_div=0 behaves as 2 clocks per bit; 0x81 (parity 0)
    bus.clk_div = 4'd0;
    ticks(4);
    clear_counts();
    send_frame(8'h81, 1'b1, 1'b0, 2);
    ticks(10);
    chk("div0_nvalid", 32'(n_valid), 32'd1);
    chk("div0_data",   32'(bus.Rx_Data), 32'h81);
    bus.clk_div = 4'd10;
    ticks(4);

    // Back-to-back frames 0x01 (parity 1) then 0xFF (parity 0)
    clear_counts();
    send_frame(8'h01, 1'b1, 1'b1, 10);
    send_frame(8'hFF, 1'b1, 1'b0, 10);
    ticks(20);
    chk("b2b_nvalid", 32'(n_valid), 32'd2);
    chk("b2b_first",  32'(rx_q.size() > 0 ? rx_q[0] : 8'h00), 32'h01);
    chk("b2b_second", 32'(rx_q.size() > 1 ? rx_q[1] : 8'h00), 32'hFF);
    chk("b2b_ferr",   32'(n_ferr), 32'd0);

    // Reset during bit 3 of a frame (0xE7)
    clear_counts();
    bus.Rx_Serial = 1'b0;
    ticks(10);
    for (int i = 0; i < 4; i++) begin
      bus.Rx_Serial = (8'hE7 >> i) & 8'h01;
      ticks(i == 3 ? 5 : 10);
    end
    chk("mid_active_before", 32'(bus.Rx_Active), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_data",   32'(bus.Rx_Data),   32'h00);
    chk("mid_rst_active", 32'(bus.Rx_Active), 32'h0);
    bus.Rx_Serial = 1'b1;
    ticks(2);
    rst = 1'b1;
    ticks(120);
    chk("mid_rst_nvalid", 32'(n_valid), 32'd0);
    chk("mid_rst_nferr",  32'(n_ferr),  32'd0);
    chk("mid_rst_data_hold", 32'(bus.Rx_Data), 32'h00);

    // Clean frame after the aborted one: 0x96 (parity 0)
    clear_counts();
    send_frame(8'h96, 1'b1, 1'b0, 10);
    ticks(20);
    chk("post_rst_nvalid", 32'(n_valid), 32'd1);
    chk("post_rst_data",   32'(bus.Rx_Data), 32'h96);

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight: parity bit 0 is wrong, 1 is right
    clear_counts();
    send_frame(8'h07, 1'b1, 1'b0, 10);
    ticks(20);
    chk("par_bad_perr",   32'(n_perr),  32'd1);
    chk("par_bad_nvalid", 32'(n_valid), 32'd0);
    chk("par_bad_data",   32'(bus.Rx_Data), 32'h96);
    clear_counts();
    send_frame(8'h07, 1'b1, 1'b1, 10);
    ticks(20);
    chk("par_good_nvalid", 32'(n_valid), 32'd1);
    chk("par_good_perr",   32'(n_perr),  32'd0);
    chk("par_good_data",   32'(bus.Rx_Data), 32'h07);
`else
    chk("perr_tied", 32'(n_perr), 32'd0);
`endif

    chk("strobe_exclusive", 32'(n_excl), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
